operand_stream_buffer: RTL

OPERAND_STREAM_BUFFER -- requirements
Module: operand_stream_buffer

---
 rtl/operand_stream_buffer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/operand_stream_buffer.sv
// Ping-pong operand buffer: per channel, two banks of DEPTH beats, loaded
// and streamed independently. Optional bank replay port: OSB_REPLAY_EN.
module operand_stream_buffer #(
    parameter int NUM_CH = 3,
    parameter int ROWS   = 4,
    parameter int DEPTH  = 64,
    parameter int DATA_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             wr_valid,
    output logic [NUM_CH-1:0]             wr_ready,
    input  logic [NUM_CH*ROWS*DATA_W-1:0] wr_data,
    output logic [NUM_CH-1:0]             rd_valid,
    input  logic [NUM_CH-1:0]             rd_ready,
    output logic [NUM_CH*ROWS*DATA_W-1:0] rd_data,
    output logic [NUM_CH-1:0]             rd_last,
    input  logic [NUM_CH-1:0]             flush,
`ifdef OSB_REPLAY_EN
    input  logic [NUM_CH-1:0]             replay,
`endif
    output logic [NUM_CH*2-1:0]           bank_cnt
);

    localparam int BEAT_W = ROWS * DATA_W;
    localparam int AW     = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    for (genvar c = 0; c < NUM_CH; c++) begin : gCh
        logic [BEAT_W-1:0] bankMem [2*DEPTH];

        logic          wrBank;
        logic          rdBank;
        logic [AW-1:0] wrPtr;
        logic [AW-1:0] rdPtr;
        logic [1:0]    full;
        logic [1:0]    bankCnt;

        logic          wrBankNext;
        logic          rdBankNext;
        logic [AW-1:0] wrPtrNext;
        logic [AW-1:0] rdPtrNext;
        logic [1:0]    fullNext;

        logic wrFire;
        logic rdFire;
        logic wrEnd;
        logic rdEnd;
        logic replayHit;

        // Handshakes and end-of-bank events on each side
        always_comb begin
            wrFire = wr_valid[c] & ~full[wrBank];
            rdFire = rd_ready[c] & full[rdBank];
            wrEnd  = wrFire & (wrPtr == LAST_PTR);
            rdEnd  = rdFire & (rdPtr == LAST_PTR);
        end

`ifdef OSB_REPLAY_EN
        assign replayHit = rdEnd & replay[c];
`else
        assign replayHit = 1'b0;
`endif

        // Next pointers, bank selects and full flags; flush wins
        always_comb begin
            wrPtrNext  = wrPtr;
            rdPtrNext  = rdPtr;
            wrBankNext = wrBank;
            rdBankNext = rdBank;
            fullNext   = full;
            if (wrFire) begin
                wrPtrNext = wrPtr + AW'(1);
            end
            if (wrEnd) begin
                fullNext[wrBank] = 1'b1;
                wrBankNext       = ~wrBank;
            end
            if (rdFire) begin
                rdPtrNext = rdPtr + AW'(1);
            end
            if (rdEnd && !replayHit) begin
                fullNext[rdBank] = 1'b0;
                rdBankNext       = ~rdBank;
            end
            if (flush[c]) begin
                wrPtrNext  = '0;
                rdPtrNext  = '0;
                wrBankNext = 1'b0;
                rdBankNext = 1'b0;
                fullNext   = '0;
            end
        end

        // Channel control state and registered bank count
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wrPtr   <= '0;
                rdPtr   <= '0;
                wrBank  <= 1'b0;
                rdBank  <= 1'b0;
                full    <= '0;
                bankCnt <= '0;
            end else begin
                wrPtr   <= wrPtrNext;
                rdPtr   <= rdPtrNext;
                wrBank  <= wrBankNext;
                rdBank  <= rdBankNext;
                full    <= fullNext;
                bankCnt <= {1'b0, fullNext[1]} + {1'b0, fullNext[0]};
            end
        end

        // Bank storage, written on accepted load beats only
        always_ff @(posedge clk) begin
            if (wrFire) begin
                bankMem[{wrBank, wrPtr}] <= wr_data[c*BEAT_W +: BEAT_W];
            end
        end

        assign wr_ready[c]              = ~full[wrBank];
        assign rd_valid[c]              = full[rdBank];
        assign rd_last[c]               = full[rdBank] & (rdPtr == LAST_PTR);
        assign rd_data[c*BEAT_W +: BEAT_W] = bankMem[{rdBank, rdPtr}];
        assign bank_cnt[c*2 +: 2]       = bankCnt;
    end

endmodule
